// File: rtl/egress_arbiter.sv
// egress_arbiter: drains eight FWFT FIFOs into one registered valid/ready stream,
// round-robin with bounded bursts, tagging each word with its source port.
module egress_arbiter #(
    parameter int N_PORTS = 8,
    parameter int DATA_W  = 32,
    parameter int BURST   = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_PORTS-1:0]        fifo_empty,
    input  logic [N_PORTS*DATA_W-1:0] fifo_data,
    output logic [N_PORTS-1:0]        fifo_pop,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         dataout,
    output logic                      dataValid,
    output logic [2:0]                address,
    output logic                      busy
);
    typedef enum logic {IDLE, SERVE} state_t;
    state_t            state, state_nxt;
    logic [2:0]        rr_ptr, grant, sel, idx, pop_idx;
    logic [4:0]        burst_cnt;
    logic              any, load_en, eob, do_pop;
    logic [DATA_W-1:0] heads [N_PORTS];
    for (genvar g = 0; g < N_PORTS; g++) begin : g_head
        assign heads[g] = fifo_data[g*DATA_W +: DATA_W];
    end
    assign load_en = !dataValid || out_ready;
    assign eob     = fifo_empty[grant] || burst_cnt == 5'(BURST);
    assign any     = ~&fifo_empty;
    assign pop_idx = state == IDLE ? sel : grant;
    assign do_pop  = state == IDLE ? load_en && any : load_en && !eob;
    // Scanning downwards leaves the first non-empty port at or after rr_ptr in sel
    always_comb begin
        sel = rr_ptr;
        idx = rr_ptr;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            idx = rr_ptr + 3'(k);
            if (!fifo_empty[idx]) sel = idx;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state == IDLE ? (do_pop ? SERVE : IDLE) : (eob ? IDLE : SERVE);
    end
    always_comb begin
        fifo_pop = (reset_n && do_pop) ? {{(N_PORTS-1){1'b0}}, 1'b1} << pop_idx : '0;
        busy     = state == SERVE;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dataout   <= '0;
            dataValid <= 1'b0;
            address   <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            grant     <= '0;
        end else begin
            if (load_en) dataValid <= do_pop;
            if (do_pop) begin
                dataout <= heads[pop_idx];
                address <= pop_idx;
            end
            if (state == IDLE && do_pop) begin
                grant     <= sel;
                burst_cnt <= 5'd1;
            end else if (state == SERVE && eob) begin
                rr_ptr    <= grant + 3'd1;
                burst_cnt <= '0;
            end else if (do_pop) begin
                burst_cnt <= burst_cnt + 5'd1;
            end
        end
    end
endmodule

// File: tb/tb_egress_arbiter.sv
// tb_egress_arbiter: directed vectors against queue-backed FWFT FIFO models.
module tb_egress_arbiter;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         out_ready = 1'b1;
    logic [7:0]   fifo_empty;
    logic [255:0] fifo_data;
    logic [7:0]   fifo_pop;
    logic [31:0]  dataout;
    logic         dataValid;
    logic [2:0]   address;
    logic         busy;
    int checks = 0, failures = 0, cyc = 0, viol = 0, t0 = 0;
    logic [31:0] q [8][$];
    logic [34:0] obs [$];
    int          obs_t [$];
    logic [34:0] exp_w [12] = '{{3'd0, 32'h100}, {3'd0, 32'h101}, {3'd0, 32'h102}, {3'd0, 32'h103},
                                {3'd5, 32'h500}, {3'd5, 32'h501}, {3'd5, 32'h502}, {3'd5, 32'h503},
                                {3'd0, 32'h104}, {3'd0, 32'h105}, {3'd5, 32'h504}, {3'd5, 32'h505}};
    int          exp_t [12] = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12, 14, 15};

    always #5 clk = ~clk;

    egress_arbiter dut (
        .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_pop(fifo_pop), .out_ready(out_ready), .dataout(dataout),
        .dataValid(dataValid), .address(address), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < 8; i++) begin
            fifo_empty[i] = q[i].size() == 0;
            fifo_data[i*32 +: 32] = q[i].size() != 0 ? q[i][0] : 32'h0;
        end
    endtask

    // One clock: log any transfer, apply the sampled pops to the FIFO models
    task automatic cycle();
        logic [7:0] p;
        if (dataValid && out_ready) begin
            obs.push_back({address, dataout});
            obs_t.push_back(cyc);
        end
        if (!$onehot0(fifo_pop) || (fifo_pop & fifo_empty) != 8'h0) viol++;
        p = fifo_pop;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 8; i++) if (p[i] && q[i].size() != 0) void'(q[i].pop_front());
        refresh();
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            q[i].push_back(32'hF0 + i);
            q[i].push_back(32'hE0 + i);
        end
        refresh();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rst_pop", fifo_pop, 8'h00);
            check("rst_valid", dataValid, 1'b0);
            check("rst_data", dataout, 32'h0);
            check("rst_busy", busy, 1'b0);
        end
        for (int i = 0; i < 8; i++) q[i].delete();
        refresh();
        do_reset();

        for (int k = 0; k < 6; k++) begin
            q[0].push_back(32'h100 + k);
            q[5].push_back(32'h500 + k);
        end
        refresh();
        #1;
        obs.delete();
        obs_t.delete();
        t0 = cyc;
        run(18);
        check("burst_count", obs.size(), 12);
        for (int i = 0; i < 12 && i < obs.size(); i++) begin
            check("burst_word", obs[i], exp_w[i]);
            check("burst_time", obs_t[i] - t0, exp_t[i]);
        end
        do_reset();

        q[3].push_back(32'hA1);
        q[3].push_back(32'hB2);
        refresh();
        #1;
        check("single_pop0", fifo_pop, 8'h08);
        cycle();
        check("single_d0", dataout, 32'hA1);
        check("single_a0", address, 3'd3);
        check("single_v0", dataValid, 1'b1);
        check("single_pop1", fifo_pop, 8'h08);
        cycle();
        check("single_d1", dataout, 32'hB2);
        check("single_eob_pop", fifo_pop, 8'h00);
        check("single_busy", busy, 1'b1);
        cycle();
        check("single_idle_v", dataValid, 1'b0);
        check("single_idle_busy", busy, 1'b0);
        q[0].push_back(32'h10);
        q[4].push_back(32'h40);
        refresh();
        #1;
        check("rr4_pop", fifo_pop, 8'h10);
        cycle();
        check("rr4_addr", address, 3'd4);
        check("rr4_data", dataout, 32'h40);
        cycle();
        check("rr5_pop", fifo_pop, 8'h01);
        cycle();
        check("rr5_addr", address, 3'd0);
        check("rr5_data", dataout, 32'h10);
        run(2);

        for (int k = 0; k < 6; k++) q[2].push_back(32'h200 + k);
        refresh();
        #1;
        check("bp_pop0", fifo_pop, 8'h04);
        cycle();
        check("bp_d0", dataout, 32'h200);
        cycle();
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_data", dataout, 32'h201);
            check("bp_hold_addr", address, 3'd2);
            check("bp_hold_valid", dataValid, 1'b1);
            check("bp_hold_pop", fifo_pop, 8'h00);
            cycle();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_pop", fifo_pop, 8'h04);
        cycle();
        check("bp_d2", dataout, 32'h202);
        cycle();
        check("bp_d3", dataout, 32'h203);
        check("bp_burst_end", fifo_pop, 8'h00);
        check("bp_busy", busy, 1'b1);
        cycle();
        check("bp_rearb_pop", fifo_pop, 8'h04);
        check("bp_rearb_valid", dataValid, 1'b0);
        run(4);

        q[6].push_back(32'h600);
        q[7].push_back(32'h700);
        q[1].push_back(32'h100);
        refresh();
        #1;
        check("wrap_p6", fifo_pop, 8'h40);
        cycle();
        check("wrap_a6", address, 3'd6);
        cycle();
        check("wrap_p7", fifo_pop, 8'h80);
        cycle();
        check("wrap_a7", address, 3'd7);
        check("wrap_d7", dataout, 32'h700);
        cycle();
        check("wrap_p1", fifo_pop, 8'h02);
        cycle();
        check("wrap_a1", address, 3'd1);
        run(2);

        for (int k = 0; k < 3; k++) q[2].push_back(32'h220 + k);
        refresh();
        #1;
        check("rstm_pop0", fifo_pop, 8'h04);
        cycle();
        cycle();
        check("rstm_d1", dataout, 32'h221);
        reset_n = 1'b0;
        #1;
        check("rstm_pop_gated", fifo_pop, 8'h00);
        cycle();
        check("rstm_valid", dataValid, 1'b0);
        check("rstm_busy", busy, 1'b0);
        reset_n = 1'b1;
        q[0].push_back(32'h0A0);
        refresh();
        #1;
        check("rstm_restart_pop", fifo_pop, 8'h01);
        cycle();
        check("rstm_restart_addr", address, 3'd0);
        check("rstm_restart_data", dataout, 32'h0A0);
        run(4);
        check("pop_legal", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
